dla_kpe_ctrl: RTL and testbench

Per-KPE sequencer that turns a job descriptor (kernel length, output count, precision, bypass) into the cycle-accurate control strobes of one KPE MAC lane. It gates an upstream operand stream (ifmap/weight pairs) into the KPE and aligns the src, mul and acc enables with the KPE's 3-stage pipeline. It also issues an accumulator reset at the start of each output and flags each finished partial sum. It sits between the array-level scheduler (job descriptors) and one `dla_kpe` instance.

---
 rtl/dla_kpe_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_dla_kpe_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dla_kpe_ctrl.sv
// dla_kpe_ctrl: per-KPE job sequencer. It gates an operand stream into one
// KPE MAC lane and drives the src/mul/acc strobes in step with the lane's
// three-stage pipeline. It also flags each finished partial sum and pulses
// done at the end of a job.

package dla_kpe_pkg;
  typedef enum logic [1:0] {
    PREC_IFMAP_INT8 = 2'd0,
    PREC_IFMAP_INT4 = 2'd1,
    PREC_IFMAP_INT2 = 2'd2,
    PREC_IFMAP_BIN  = 2'd3
  } precision_ifmap_e;

  typedef enum logic [1:0] {
    PREC_WEIGHT_INT8 = 2'd0,
    PREC_WEIGHT_INT4 = 2'd1,
    PREC_WEIGHT_INT2 = 2'd2,
    PREC_WEIGHT_BIN  = 2'd3
  } precision_weight_e;
endpackage

module dla_kpe_ctrl
  import dla_kpe_pkg::*;
#(
  parameter int KLEN_W = 16,
  parameter int NOUT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [KLEN_W-1:0] cfg_klen_m1,
  input  logic [NOUT_W-1:0] cfg_nout_m1,
  input  logic [3:0]        cfg_shift,
  input  precision_ifmap_e  cfg_prec_ifmap,
  input  precision_weight_e cfg_prec_weight,
  input  logic              cfg_bypass,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              enable,
  output logic              ctrl_kpe_src0_enable,
  output logic              ctrl_kpe_src1_enable,
  output logic              ctrl_kpe_mul_enable,
  output logic              ctrl_kpe_acc_enable,
  output logic              ctrl_kpe_acc_rst,
  output logic              ctrl_kpe_bypass,
  output logic [3:0]        stgr_precision_kpe_shift,
  output precision_ifmap_e  stgr_precision_ifmap,
  output precision_weight_e stgr_precision_weight,
  output logic              sum_valid,
  output logic [NOUT_W-1:0] sum_idx,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e            r_state;
  state_e            w_state_next;

  logic [KLEN_W-1:0] r_klen_m1;
  logic [NOUT_W-1:0] r_nout_m1;
  logic [KLEN_W-1:0] r_k_cnt;
  logic [NOUT_W-1:0] r_o_cnt;

  // Stage tags: index 0 = mul stage, 1 = acc stage, 2 = sum-ready slot.
  // "first" only matters up to the acc stage, so it is two deep.
  logic [2:0]        r_tag_valid;
  logic [1:0]        r_tag_first;
  logic [2:0]        r_tag_last;
  logic [NOUT_W-1:0] r_tag_idx [3];

  logic              w_beat;
  logic              w_accept;
  logic              w_k_last;
  logic              w_o_last;

  assign w_beat   = in_valid & in_ready;
  assign w_accept = (r_state == S_IDLE) & cfg_valid & ~abort;
  assign w_k_last = (r_k_cnt == r_klen_m1);
  assign w_o_last = (r_o_cnt == r_nout_m1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and state-decoded handshake outputs; abort overrides everything.
  always_comb begin
    w_state_next = r_state;
    cfg_ready    = 1'b0;
    in_ready     = 1'b0;
    enable       = 1'b1;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        cfg_ready = 1'b1;
        enable    = 1'b0;
        if (cfg_valid) w_state_next = S_RUN;
      end
      S_RUN: begin
        in_ready = 1'b1;
        if (in_valid && w_k_last && w_o_last) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        // The final beat's tag is in the sum-ready slot once both earlier
        // stages are empty, so this is also the cycle of the last sum_valid.
        if (!r_tag_valid[0] && !r_tag_valid[1]) w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (abort) w_state_next = S_IDLE;
  end

  // Descriptor latch and MAC/output counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_klen_m1                <= '0;
      r_nout_m1                <= '0;
      r_k_cnt                  <= '0;
      r_o_cnt                  <= '0;
      ctrl_kpe_bypass          <= 1'b0;
      stgr_precision_kpe_shift <= 4'd0;
      stgr_precision_ifmap     <= PREC_IFMAP_INT8;
      stgr_precision_weight    <= PREC_WEIGHT_INT8;
    end else if (w_accept) begin
      // A bypass job is a single-term pass-through per output.
      r_klen_m1                <= cfg_bypass ? '0 : cfg_klen_m1;
      r_nout_m1                <= cfg_nout_m1;
      r_k_cnt                  <= '0;
      r_o_cnt                  <= '0;
      ctrl_kpe_bypass          <= cfg_bypass;
      stgr_precision_kpe_shift <= cfg_shift;
      stgr_precision_ifmap     <= cfg_prec_ifmap;
      stgr_precision_weight    <= cfg_prec_weight;
    end else if (w_beat && !abort) begin
      if (w_k_last) begin
        r_k_cnt <= '0;
        r_o_cnt <= r_o_cnt + 1'b1;
      end else begin
        r_k_cnt <= r_k_cnt + 1'b1;
      end
    end
  end

  // Tag shift register; a non-beat cycle shifts in an empty bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_valid <= '0;
      r_tag_first <= '0;
      r_tag_last  <= '0;
      for (int i = 0; i < 3; i++) r_tag_idx[i] <= '0;
    end else if (abort) begin
      r_tag_valid <= '0;
      r_tag_first <= '0;
      r_tag_last  <= '0;
      for (int i = 0; i < 3; i++) r_tag_idx[i] <= '0;
    end else begin
      r_tag_valid  <= {r_tag_valid[1:0], w_beat};
      r_tag_first  <= {r_tag_first[0], w_beat & (r_k_cnt == '0)};
      r_tag_last   <= {r_tag_last[1:0], w_beat & w_k_last};
      r_tag_idx[0] <= w_beat ? r_o_cnt : '0;
      r_tag_idx[1] <= r_tag_idx[0];
      r_tag_idx[2] <= r_tag_idx[1];
    end
  end

  assign ctrl_kpe_src0_enable = w_beat;
  assign ctrl_kpe_src1_enable = w_beat;
  assign ctrl_kpe_mul_enable  = r_tag_valid[0];
  assign ctrl_kpe_acc_enable  = r_tag_valid[1];
  assign ctrl_kpe_acc_rst     = r_tag_valid[1] & r_tag_first[1];
  assign sum_valid            = r_tag_valid[2] & r_tag_last[2];
  assign sum_idx              = r_tag_idx[2];

endmodule

// File: tb/tb_dla_kpe_ctrl.sv
// Bench for dla_kpe_ctrl: directed job scenarios plus a randomized phase.
// All of them are checked cycle by cycle against a beat-history model.
module tb_dla_kpe_ctrl;
  import dla_kpe_pkg::*;

  localparam int KLEN_W = 16;
  localparam int NOUT_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [KLEN_W-1:0] cfg_klen_m1;
  logic [NOUT_W-1:0] cfg_nout_m1;
  logic [3:0]        cfg_shift;
  precision_ifmap_e  cfg_prec_ifmap;
  precision_weight_e cfg_prec_weight;
  logic              cfg_bypass;
  logic              abort;
  logic              in_valid;
  logic              in_ready;
  logic              enable;
  logic              src0_en, src1_en, mul_en, acc_en, acc_rst, kpe_bypass;
  logic [3:0]        kpe_shift;
  precision_ifmap_e  prec_ifmap;
  precision_weight_e prec_weight;
  logic              sum_valid;
  logic [NOUT_W-1:0] sum_idx;
  logic              done;

  dla_kpe_ctrl #(.KLEN_W(KLEN_W), .NOUT_W(NOUT_W)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .cfg_valid                (cfg_valid),
    .cfg_ready                (cfg_ready),
    .cfg_klen_m1              (cfg_klen_m1),
    .cfg_nout_m1              (cfg_nout_m1),
    .cfg_shift                (cfg_shift),
    .cfg_prec_ifmap           (cfg_prec_ifmap),
    .cfg_prec_weight          (cfg_prec_weight),
    .cfg_bypass               (cfg_bypass),
    .abort                    (abort),
    .in_valid                 (in_valid),
    .in_ready                 (in_ready),
    .enable                   (enable),
    .ctrl_kpe_src0_enable     (src0_en),
    .ctrl_kpe_src1_enable     (src1_en),
    .ctrl_kpe_mul_enable      (mul_en),
    .ctrl_kpe_acc_enable      (acc_en),
    .ctrl_kpe_acc_rst         (acc_rst),
    .ctrl_kpe_bypass          (kpe_bypass),
    .stgr_precision_kpe_shift (kpe_shift),
    .stgr_precision_ifmap     (prec_ifmap),
    .stgr_precision_weight    (prec_weight),
    .sum_valid                (sum_valid),
    .sum_idx                  (sum_idx),
    .done                     (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;
  int cyc      = 0;

  // Reference model: job bookkeeping plus a 4-entry history of beats.
  // Beat n of a job with K MACs per output is term n%K of output n/K.
  bit      m_busy;
  longint  m_nbeats, m_total;
  int      m_k;
  int      m_done_cyc;
  bit      h_valid [4];
  longint  h_n     [4];
  int      h_k     [4];
  bit [3:0] m_shift;
  bit [1:0] m_pi, m_pw;
  bit      m_byp;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_nbeats = 0; m_total = 0; m_k = 1; m_done_cyc = -1;
    m_shift = 0; m_pi = 0; m_pw = 0; m_byp = 0;
    for (int i = 0; i < 4; i++) begin
      h_valid[i] = 0; h_n[i] = 0; h_k[i] = 1;
    end
  endtask

  task automatic check_reset_outputs();
    check_val("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check_val("rst_in_ready",  32'(in_ready),  32'd0);
    check_val("rst_enable",    32'(enable),    32'd0);
    check_val("rst_src0",      32'(src0_en),   32'd0);
    check_val("rst_mul",       32'(mul_en),    32'd0);
    check_val("rst_acc",       32'(acc_en),    32'd0);
    check_val("rst_acc_rst",   32'(acc_rst),   32'd0);
    check_val("rst_sum_valid", 32'(sum_valid), 32'd0);
    check_val("rst_sum_idx",   32'(sum_idx),   32'd0);
    check_val("rst_done",      32'(done),      32'd0);
    check_val("rst_bypass",    32'(kpe_bypass), 32'd0);
    check_val("rst_shift",     32'(kpe_shift), 32'd0);
    check_val("rst_prec_if",   32'(prec_ifmap), 32'd0);
    check_val("rst_prec_wt",   32'(prec_weight), 32'd0);
  endtask

  // One clock cycle: compare outputs at the falling edge, then advance the
  // model with the inputs the DUT sees at the coming rising edge.
  task automatic tick();
    bit     e_run, beat, e_mul, e_acc, e_rst, e_sv, e_done;
    longint e_idx;
    int     p1, p2, p3, cur;
    @(negedge clk);
    cur    = cyc % 4;
    p1     = (cyc + 3) % 4;
    p2     = (cyc + 2) % 4;
    p3     = (cyc + 1) % 4;
    e_run  = m_busy && (m_nbeats < m_total);
    beat   = e_run && in_valid;
    e_mul  = h_valid[p1];
    e_acc  = h_valid[p2];
    e_rst  = h_valid[p2] && ((h_n[p2] % h_k[p2]) == 0);
    e_sv   = h_valid[p3] && ((h_n[p3] % h_k[p3]) == h_k[p3] - 1);
    e_idx  = h_n[p3] / h_k[p3];
    e_done = m_busy && (cyc == m_done_cyc);

    check_val("cfg_ready", 32'(cfg_ready), 32'(!m_busy));
    check_val("in_ready",  32'(in_ready),  32'(e_run));
    check_val("enable",    32'(enable),    32'(m_busy));
    check_val("src0_en",   32'(src0_en),   32'(beat));
    check_val("src1_en",   32'(src1_en),   32'(beat));
    check_val("mul_en",    32'(mul_en),    32'(e_mul));
    check_val("acc_en",    32'(acc_en),    32'(e_acc));
    check_val("acc_rst",   32'(acc_rst),   32'(e_rst));
    check_val("sum_valid", 32'(sum_valid), 32'(e_sv));
    if (e_sv) begin
      check_val("sum_idx", 32'(sum_idx), 32'(e_idx));
      $display("sum: cycle %0d idx %0d", cyc, sum_idx);
    end
    check_val("done",      32'(done),      32'(e_done));
    check_val("bypass",    32'(kpe_bypass), 32'(m_byp));
    check_val("shift",     32'(kpe_shift), 32'(m_shift));
    check_val("prec_if",   32'(prec_ifmap), 32'(m_pi));
    check_val("prec_wt",   32'(prec_weight), 32'(m_pw));

    h_valid[cur] = 0;
    if (abort) begin
      if (m_busy) $display("job: aborted at cycle %0d", cyc);
      m_busy = 0;
      for (int i = 0; i < 4; i++) h_valid[i] = 0;
    end else if (!m_busy) begin
      if (cfg_valid) begin
        m_k        = cfg_bypass ? 1 : int'(cfg_klen_m1) + 1;
        m_total    = longint'(m_k) * (longint'(cfg_nout_m1) + 1);
        m_nbeats   = 0;
        m_busy     = 1;
        m_done_cyc = -1;
        m_shift    = cfg_shift;
        m_pi       = 2'(cfg_prec_ifmap);
        m_pw       = 2'(cfg_prec_weight);
        m_byp      = cfg_bypass;
        $display("job: accepted cycle %0d macs=%0d outputs=%0d bypass=%0d", cyc, m_k, cfg_nout_m1 + 1, cfg_bypass);
      end
    end else begin
      if (e_done) $display("job: done at cycle %0d", cyc);
      if (beat) begin
        h_valid[cur] = 1;
        h_n[cur]     = m_nbeats;
        h_k[cur]     = m_k;
        m_nbeats++;
        if (m_nbeats == m_total) m_done_cyc = cyc + 4;
      end
      if (cyc == m_done_cyc) m_busy = 0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int klen, input int nout, input int shift,
                           input int pi, input int pw, input bit byp);
    cfg_klen_m1     = KLEN_W'(klen);
    cfg_nout_m1     = NOUT_W'(nout);
    cfg_shift       = 4'(shift);
    cfg_prec_ifmap  = precision_ifmap_e'(2'(pi));
    cfg_prec_weight = precision_weight_e'(2'(pw));
    cfg_bypass      = byp;
    cfg_valid       = 1'b1;
    tick();
    cfg_valid       = 1'b0;
  endtask

  // mode 0: in_valid held high; 1: alternating 1,0,1,...; 2: random.
  task automatic run_job(input int mode);
    int i;
    i = 0;
    while (m_busy && i < 500) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (i % 2 == 0);
        default: in_valid = ($urandom % 3) != 0;
      endcase
      tick();
      i++;
    end
    in_valid = 1'b0;
    if (m_busy) check_val("job_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    cfg_valid = 0; cfg_klen_m1 = 0; cfg_nout_m1 = 0; cfg_shift = 0;
    cfg_prec_ifmap = PREC_IFMAP_INT8; cfg_prec_weight = PREC_WEIGHT_INT8;
    cfg_bypass = 0; abort = 0; in_valid = 0;
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;

    // Back-to-back outputs.
    start_job(3, 1, 2, 1, 1, 0);
    run_job(0);
    // Bubbles.
    start_job(2, 0, 1, 2, 3, 0);
    run_job(1);
    // Bypass job: klen forced to one MAC.
    start_job(5, 2, 3, 1, 2, 1);
    run_job(0);
    // Abort after two beats, with a competing descriptor that must be ignored.
    start_job(5, 1, 4, 3, 0, 0);
    in_valid = 1'b1;
    tick();
    tick();
    abort = 1'b1;
    cfg_valid = 1'b1; cfg_klen_m1 = 1; cfg_nout_m1 = 1; cfg_shift = 9; cfg_bypass = 0;
    tick();
    abort = 1'b0;
    tick();
    cfg_valid = 1'b0;
    run_job(2);
    // Minimum job.
    start_job(0, 0, 7, 2, 1, 0);
    run_job(0);

    // Asynchronous reset between clock edges while draining.
    start_job(1, 0, 5, 1, 3, 1);
    in_valid = 1'b1;
    guard = 0;
    while (!(m_busy && m_nbeats == m_total) && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check_val("drain_timeout", 32'd1, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    cyc++;

    // Randomized traffic: descriptors, bubbles and occasional aborts.
    for (int c = 0; c < 1500; c++) begin
      cfg_valid       = ($urandom % 6) == 0;
      cfg_klen_m1     = KLEN_W'($urandom_range(0, 5));
      cfg_nout_m1     = NOUT_W'($urandom_range(0, 3));
      cfg_shift       = 4'($urandom);
      cfg_prec_ifmap  = precision_ifmap_e'(2'($urandom));
      cfg_prec_weight = precision_weight_e'(2'($urandom));
      cfg_bypass      = ($urandom % 4) == 0;
      in_valid        = ($urandom % 4) != 0;
      abort           = ($urandom % 64) == 0;
      tick();
    end
    cfg_valid = 0; in_valid = 0; abort = 0;
    for (int c = 0; c < 20; c++) tick();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
